// File: rtl/cardinal_dmem_arbiter_if.sv
// Requester-side bundle of the dmem arbiter: per-requester request,
// lock, direction, address and write data in; one-hot grant/rvalid out.
interface cardinal_dmem_arbiter_if #(
   parameter int NREQ   = 4,
   parameter int ADDR_W = 8,
   parameter int DATA_W = 64
);
   logic [NREQ-1:0]        req;
   logic [NREQ-1:0]        lock;
   logic [NREQ-1:0]        wr;
   logic [NREQ*ADDR_W-1:0] addr;
   logic [NREQ*DATA_W-1:0] wdata;
   logic [NREQ-1:0]        gnt;
   logic [NREQ-1:0]        rvalid;
   logic [DATA_W-1:0]      rdata;

   modport master (
      output req, lock, wr, addr, wdata,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, lock, wr, addr, wdata,
      output gnt, rvalid, rdata
   );
endinterface

// File: rtl/cardinal_dmem_arbiter.sv
// Round-robin dmem arbiter with bounded burst lock and tagged read return.
// Ports: clk, reset (async high), bus (requesters), memEn/memWrEn/memAddr/dmem_din/dmem_dout (dmem).
module cardinal_dmem_arbiter #(
   parameter int NREQ      = 4,
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 64,
   parameter int MAX_BURST = 4
) (
   input  logic                clk,
   input  logic                reset,
   cardinal_dmem_arbiter_if.slave bus,
   output logic                memEn,
   output logic                memWrEn,
   output logic [ADDR_W-1:0]   memAddr,
   output logic [DATA_W-1:0]   dmem_din,
   input  logic [DATA_W-1:0]   dmem_dout
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(MAX_BURST + 1);

   logic [PW-1:0]   ptr_q, ptr_d;
   logic            own_vld_q, own_vld_d;
   logic [PW-1:0]   own_q, own_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [NREQ-1:0] rv_q, rv_d;

   logic            gvld;
   logic [PW-1:0]   gidx;
   logic [PW-1:0]   cand;
   logic [CW-1:0]   cnt_n;
   logic [NREQ-1:0] gnt_oh;

   // Grant selection: locked owner first, otherwise RR search from ptr.
   always_comb begin
      gvld = 1'b0;
      gidx = '0;
      cand = '0;
      if (own_vld_q && bus.req[own_q] && (cnt_q < CW'(MAX_BURST))) begin
         gvld = 1'b1;
         gidx = own_q;
      end else begin
         for (int k = 0; k < NREQ; k++) begin
            cand = PW'((int'(ptr_q) + k) % NREQ);
            if (!gvld && bus.req[cand]) begin
               gvld = 1'b1;
               gidx = cand;
            end
         end
      end
      // Grant is forced off while reset is held, even with requests present.
      if (reset) gvld = 1'b0;
   end

   always_comb begin
      gnt_oh   = '0;
      memWrEn  = 1'b0;
      memAddr  = '0;
      dmem_din = '0;
      if (gvld) gnt_oh[gidx] = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_oh[i]) begin
            memWrEn  = bus.wr[i];
            memAddr  = bus.addr[i*ADDR_W +: ADDR_W];
            dmem_din = bus.wdata[i*DATA_W +: DATA_W];
         end
      end
      memEn = gvld;
   end

   assign bus.gnt    = gnt_oh;
   assign bus.rvalid = rv_q;
   assign bus.rdata  = dmem_dout;

   always_comb begin
      ptr_d     = ptr_q;
      own_vld_d = 1'b0;
      own_d     = own_q;
      cnt_d     = '0;
      rv_d      = '0;
      cnt_n     = '0;
      if (gvld) begin
         ptr_d = (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
         if (bus.lock[gidx]) begin
            cnt_n = (own_vld_q && (own_q == gidx)) ? cnt_q + 1'b1 : CW'(1);
            // Hitting the cap releases the lock on this same edge.
            if (cnt_n != CW'(MAX_BURST)) begin
               own_vld_d = 1'b1;
               own_d     = gidx;
               cnt_d     = cnt_n;
            end
         end
         if (!bus.wr[gidx]) rv_d = gnt_oh;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q     <= '0;
         own_vld_q <= 1'b0;
         own_q     <= '0;
         cnt_q     <= '0;
         rv_q      <= '0;
      end else begin
         ptr_q     <= ptr_d;
         own_vld_q <= own_vld_d;
         own_q     <= own_d;
         cnt_q     <= cnt_d;
         rv_q      <= rv_d;
      end
   end
endmodule

// File: tb/tb_cardinal_dmem_arbiter.sv
// Scoreboard bench for cardinal_dmem_arbiter with a bench-side dmem model.
// Expected read returns are queued at grant time and popped one cycle later.
module tb_cardinal_dmem_arbiter;
   logic        clk = 1'b0;
   logic        reset;
   logic        memEn, memWrEn;
   logic [7:0]  memAddr;
   logic [63:0] dmem_din;
   logic [63:0] dmem_dout;

   cardinal_dmem_arbiter_if #(.NREQ(4), .ADDR_W(8), .DATA_W(64)) bus ();

   cardinal_dmem_arbiter #(
      .NREQ(4), .ADDR_W(8), .DATA_W(64), .MAX_BURST(4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .memEn     (memEn),
      .memWrEn   (memWrEn),
      .memAddr   (memAddr),
      .dmem_din  (dmem_din),
      .dmem_dout (dmem_dout)
   );

   always #5 clk = ~clk;

   logic [63:0] mem [256];
   always @(posedge clk) begin
      if (memEn) begin
         if (memWrEn) mem[memAddr] <= dmem_din;
         else         dmem_dout    <= mem[memAddr];
      end
   end

   typedef struct {
      logic [3:0]  rv;
      logic [63:0] d;
   } exp_t;
   exp_t sb [$];

   logic [7:0] addr_tab [4];
   int n_chk  = 0;
   int n_pass = 0;
   int gcnt [4];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic step(input logic [3:0] r, input logic [3:0] l,
                       input logic [3:0] w, input logic [3:0] eg,
                       input string tag);
      exp_t e;
      @(negedge clk);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk({tag, "_rvalid"}, 64'(bus.rvalid), 64'(e.rv));
         if (e.rv != 4'b0) chk({tag, "_rdata"}, bus.rdata, e.d);
      end else begin
         chk({tag, "_rvalid_idle"}, 64'(bus.rvalid), 64'h0);
      end
      bus.req  = r;
      bus.lock = l;
      bus.wr   = w;
      #1;
      chk({tag, "_gnt"}, 64'(bus.gnt), 64'(eg));
      chk({tag, "_memEn"}, 64'(memEn), 64'(|eg));
      e.rv = eg & ~w;
      e.d  = '0;
      for (int i = 0; i < 4; i++)
         if (e.rv[i]) e.d = mem[addr_tab[i]];
      sb.push_back(e);
   endtask

   initial begin
      addr_tab[0] = 8'h20;
      addr_tab[1] = 8'h05;
      addr_tab[2] = 8'h10;
      addr_tab[3] = 8'h30;
      for (int i = 0; i < 256; i++) mem[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
      mem[16] = 64'hDEAD_BEEF_0000_0001;
      dmem_dout = '0;
      bus.addr  = {8'h30, 8'h10, 8'h05, 8'h20};
      bus.wdata = {64'h3333, 64'h2222, 64'h1234, 64'h1111};

      // Reset held with all requesters active.
      reset    = 1'b1;
      bus.req  = 4'b1111;
      bus.lock = 4'b0000;
      bus.wr   = 4'b0000;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_gnt", 64'(bus.gnt), 64'h0);
      chk("rst_memEn", 64'(memEn), 64'h0);
      chk("rst_rvalid", 64'(bus.rvalid), 64'h0);
      bus.req = 4'b0000;
      @(negedge clk);
      reset = 1'b0;

      step(4'b1111, 4'b0000, 4'b0000, 4'b0001, "rst_first");

      // Round-robin fairness over 8 cycles.
      for (int i = 0; i < 4; i++) gcnt[i] = 0;
      for (int c = 0; c < 8; c++) begin
         logic [3:0] eg;
         eg = 4'b0010 << ((c % 4) == 3 ? 0 : 0);
         case (c % 4)
            0: eg = 4'b0010;
            1: eg = 4'b0100;
            2: eg = 4'b1000;
            default: eg = 4'b0001;
         endcase
         step(4'b1111, 4'b0000, 4'b0000, eg, $sformatf("rr%0d", c));
         for (int i = 0; i < 4; i++) if (bus.gnt[i]) gcnt[i]++;
      end
      for (int i = 0; i < 4; i++)
         chk($sformatf("rr_count%0d", i), 64'(gcnt[i]), 64'd2);

      // Read tag to requester 2 (dmem[0x10]); return checked by the next step.
      step(4'b0100, 4'b0000, 4'b0000, 4'b0100, "rd2");

      // Burst cap: ptr=3, requester 0 locked.
      step(4'b0011, 4'b0001, 4'b0000, 4'b0001, "burst0");
      step(4'b0011, 4'b0001, 4'b0000, 4'b0001, "burst1");
      step(4'b0011, 4'b0001, 4'b0000, 4'b0001, "burst2");
      step(4'b0011, 4'b0001, 4'b0000, 4'b0001, "burst3");
      step(4'b0011, 4'b0001, 4'b0000, 4'b0010, "burst_cap");
      step(4'b0011, 4'b0001, 4'b0000, 4'b0001, "burst_again");
      step(4'b0000, 4'b0000, 4'b0000, 4'b0000, "idle0");

      // Write from requester 1.
      step(4'b0010, 4'b0000, 4'b0010, 4'b0010, "wr1");
      chk("wr_memWrEn", 64'(memWrEn), 64'h1);
      chk("wr_memAddr", 64'(memAddr), 64'h05);
      chk("wr_din", dmem_din, 64'h1234);
      step(4'b0000, 4'b0000, 4'b0000, 4'b0000, "idle1");
      chk("wr_mem5", mem[5], 64'h1234);

      // Locked burst on requester 3 interrupted by async reset.
      step(4'b1000, 4'b1000, 4'b0000, 4'b1000, "lk3_first");
      step(4'b1001, 4'b1000, 4'b0000, 4'b1000, "lk3_hold");
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_gnt", 64'(bus.gnt), 64'h0);
      chk("arst_rvalid", 64'(bus.rvalid), 64'h0);
      chk("arst_memEn", 64'(memEn), 64'h0);
      sb.delete();
      bus.req = 4'b0000;
      @(negedge clk);
      reset = 1'b0;
      step(4'b1111, 4'b0000, 4'b0000, 4'b0001, "post_rst0");
      step(4'b1111, 4'b0000, 4'b0000, 4'b0010, "post_rst1");
      step(4'b0000, 4'b0000, 4'b0000, 4'b0000, "flush0");
      step(4'b0000, 4'b0000, 4'b0000, 4'b0000, "flush1");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
